// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 write-only controller.
// The init ROM is only used when the design is built with LCD_INIT_EN.
package lcd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PWRUP = 3'd1,
      ST_SETUP = 3'd2,
      ST_PULSE = 3'd3,
      ST_HOLD  = 3'd4,
      ST_WAIT  = 3'd5
   } lcd_state_e;

   localparam logic [7:0] LCD_CMD_CLEAR   = 8'h01;
   localparam logic [7:0] LCD_CMD_HOME    = 8'h02;
   localparam logic [7:0] LCD_CMD_FUNCSET = 8'h38;
   localparam logic [7:0] LCD_CMD_DISPON  = 8'h0C;
   localparam logic [7:0] LCD_CMD_ENTRY   = 8'h06;

   // The controller ignores DB0 on return-home, so 8'h03 is also a home.
   localparam logic [7:0] LCD_CMD_HOME_ALT = 8'h03;

   localparam int LCD_INIT_STEPS = 6;

   localparam logic [7:0] LCD_INIT_ROM [LCD_INIT_STEPS] = '{
      LCD_CMD_FUNCSET,
      LCD_CMD_FUNCSET,
      LCD_CMD_FUNCSET,
      LCD_CMD_DISPON,
      LCD_CMD_CLEAR,
      LCD_CMD_ENTRY
   };

   // Clear and home take ~1.6 ms inside the LCD; everything else ~40 us.
   function automatic logic needs_long_exec(input logic rs, input logic [7:0] data);
      return !rs && (data == LCD_CMD_CLEAR || data == LCD_CMD_HOME ||
                     data == LCD_CMD_HOME_ALT);
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter; done_o flags terminal count (zero).
module lcd_timer #(
   parameter int             W       = 8,
   parameter logic [W-1:0]   RST_VAL = '0
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          load_i,
   input  logic [W-1:0]  value_i,
   output logic          done_o
);

   logic [W-1:0] count_q;

   // Load on phase entry, otherwise count down and park at zero.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= RST_VAL;
      end else if (load_i) begin
         count_q <= value_i;
      end else if (count_q != '0) begin
         count_q <= count_q - W'(1);
      end
   end

   assign done_o = (count_q == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 write-only bus controller: one byte per request, full E-cycle
// timing plus execution wait, busy for the whole transaction.
// Build option LCD_INIT_EN: power-up delay followed by an autonomous
// init command sequence before firmware requests are accepted.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | waiting for a request; RS/DATA hold the last byte
//   PWRUP | power-on delay before the init sequence (LCD_INIT_EN)
//   SETUP | RS/DATA valid, E low (address setup)
//   PULSE | E high
//   HOLD  | E low, RS/DATA still held
//   WAIT  | LCD internal execution time (normal or clear/home)
module lcd_ctrl
   import lcd_pkg::*;
#(
   parameter int SETUP_CYC     = 3,
   parameter int PULSE_CYC     = 25,
   parameter int HOLD_CYC      = 2,
   parameter int EXEC_CYC      = 2000,
   parameter int LONG_EXEC_CYC = 82000,
   parameter int POWERUP_CYC   = 750000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic        rs_i,
   input  logic [7:0]  data_i,
   output logic        busy_o,
   output logic        lcd_on_o,
   output logic        lcd_en_o,
   output logic        lcd_rs_o,
   output logic        lcd_rw_o,
   output logic [7:0]  lcd_data_o
);

   localparam int MAX_CYC = max_int(max_int(max_int(SETUP_CYC, PULSE_CYC),
                                            max_int(HOLD_CYC, EXEC_CYC)),
                                    max_int(LONG_EXEC_CYC, POWERUP_CYC));
   localparam int CNT_W   = $clog2(MAX_CYC) + 1;

   localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(EXEC_CYC - 1);
   localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(LONG_EXEC_CYC - 1);

`ifdef LCD_INIT_EN
   localparam logic [CNT_W-1:0] PWRUP_LD  = CNT_W'(POWERUP_CYC - 1);
   localparam logic [CNT_W-1:0] TMR_RST   = PWRUP_LD;
   localparam lcd_state_e       RST_STATE = ST_PWRUP;
   localparam logic [2:0]       LAST_STEP = 3'(LCD_INIT_STEPS - 1);
   localparam logic [2:0]       INIT_DONE = 3'(LCD_INIT_STEPS);
`else
   localparam logic [CNT_W-1:0] TMR_RST   = '0;
   localparam lcd_state_e       RST_STATE = ST_IDLE;
`endif

   lcd_state_e        state_q, state_nxt;
   logic              rs_q, rs_nxt;
   logic [7:0]        data_q, data_nxt;
   logic              byte_ld;
   logic              en_q;
   logic              on_q;
   logic              tmr_load;
   logic [CNT_W-1:0]  tmr_value;
   logic              tmr_done;

`ifdef LCD_INIT_EN
   logic [2:0]        step_q, step_nxt;
`endif

   lcd_timer #(
      .W       (CNT_W),
      .RST_VAL (TMR_RST)
   ) u_timer (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .load_i  (tmr_load),
      .value_i (tmr_value),
      .done_o  (tmr_done)
   );

   // Next-state and byte-latch decisions.
   always_comb begin
      state_nxt = state_q;
      byte_ld   = 1'b0;
      rs_nxt    = rs_q;
      data_nxt  = data_q;
`ifdef LCD_INIT_EN
      step_nxt  = step_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (req_i) begin
               state_nxt = ST_SETUP;
               byte_ld   = 1'b1;
               rs_nxt    = rs_i;
               data_nxt  = data_i;
            end
         end
`ifdef LCD_INIT_EN
         ST_PWRUP: begin
            if (tmr_done) begin
               state_nxt = ST_SETUP;
               byte_ld   = 1'b1;
               rs_nxt    = 1'b0;
               data_nxt  = LCD_INIT_ROM[0];
            end
         end
`endif
         ST_SETUP: if (tmr_done) state_nxt = ST_PULSE;
         ST_PULSE: if (tmr_done) state_nxt = ST_HOLD;
         ST_HOLD:  if (tmr_done) state_nxt = ST_WAIT;
         ST_WAIT: begin
            if (tmr_done) begin
`ifdef LCD_INIT_EN
               if (step_q < LAST_STEP) begin
                  step_nxt  = step_q + 3'd1;
                  state_nxt = ST_SETUP;
                  byte_ld   = 1'b1;
                  rs_nxt    = 1'b0;
                  data_nxt  = LCD_INIT_ROM[step_q + 3'd1];
               end else begin
                  step_nxt  = INIT_DONE;
                  state_nxt = ST_IDLE;
               end
`else
               state_nxt = ST_IDLE;
`endif
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Reload the phase timer on every state change with that phase's length.
   always_comb begin
      tmr_load  = (state_nxt != state_q);
      tmr_value = '0;
      case (state_nxt)
         ST_SETUP: tmr_value = SETUP_LD;
         ST_PULSE: tmr_value = PULSE_LD;
         ST_HOLD:  tmr_value = HOLD_LD;
         ST_WAIT:  tmr_value = needs_long_exec(rs_q, data_q) ? LONG_LD : EXEC_LD;
`ifdef LCD_INIT_EN
         ST_PWRUP: tmr_value = PWRUP_LD;
`endif
         default:  tmr_value = '0;
      endcase
   end

   // State, pin registers; E is registered so the pin never glitches.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= RST_STATE;
         rs_q    <= 1'b0;
         data_q  <= 8'h00;
         en_q    <= 1'b0;
         on_q    <= 1'b0;
      end else begin
         state_q <= state_nxt;
         en_q    <= (state_nxt == ST_PULSE);
         on_q    <= 1'b1;
         if (byte_ld) begin
            rs_q   <= rs_nxt;
            data_q <= data_nxt;
         end
      end
   end

`ifdef LCD_INIT_EN
   // Init sequence position; parks at INIT_DONE once the ROM is exhausted.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         step_q <= 3'd0;
      end else begin
         step_q <= step_nxt;
      end
   end
`endif

   assign busy_o     = (state_q != ST_IDLE);
   assign lcd_on_o   = on_q;
   assign lcd_en_o   = en_q;
   assign lcd_rs_o   = rs_q;
   assign lcd_rw_o   = 1'b0;
   assign lcd_data_o = data_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Self-checking bench for lcd_ctrl. The reference model describes each
// transaction by its accept edge and phase lengths; outputs are derived
// arithmetically from the offset since that edge. Honours LCD_INIT_EN.
module tb_lcd_ctrl;

   localparam int S_CYC  = 2;
   localparam int P_CYC  = 4;
   localparam int H_CYC  = 1;
   localparam int E_CYC  = 10;
   localparam int L_CYC  = 30;
   localparam int PU_CYC = 20;

   localparam int NORMAL_LEN = S_CYC + P_CYC + H_CYC + E_CYC;
   localparam int LONG_LEN   = S_CYC + P_CYC + H_CYC + L_CYC;
   localparam int INIT_LEN   = PU_CYC + 5 * NORMAL_LEN + LONG_LEN;

`ifdef LCD_INIT_EN
   localparam logic INIT_BUILD = 1'b1;
`else
   localparam logic INIT_BUILD = 1'b0;
`endif

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       req_i;
   logic       rs_i;
   logic [7:0] data_i;
   logic       busy_o;
   logic       lcd_on_o;
   logic       lcd_en_o;
   logic       lcd_rs_o;
   logic       lcd_rw_o;
   logic [7:0] lcd_data_o;

   always #5 clk_i = ~clk_i;

   lcd_ctrl #(
      .SETUP_CYC     (S_CYC),
      .PULSE_CYC     (P_CYC),
      .HOLD_CYC      (H_CYC),
      .EXEC_CYC      (E_CYC),
      .LONG_EXEC_CYC (L_CYC),
      .POWERUP_CYC   (PU_CYC)
   ) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .req_i      (req_i),
      .rs_i       (rs_i),
      .data_i     (data_i),
      .busy_o     (busy_o),
      .lcd_on_o   (lcd_on_o),
      .lcd_en_o   (lcd_en_o),
      .lcd_rs_o   (lcd_rs_o),
      .lcd_rw_o   (lcd_rw_o),
      .lcd_data_o (lcd_data_o)
   );

   int n_assert = 0;
   int n_fail   = 0;

   logic [7:0] init_rom [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

   // reference model
   int         e;
   int         m_t0;
   int         m_total;
   int         m_init_left;
   logic       m_pwrup;
   logic       m_busy;
   logic       m_en;
   logic       m_rs;
   logic       m_on;
   logic [7:0] m_data;

   // observations of the DUT pins
   int         en_pulses;
   int         busy_cnt;
   int         first_en_edge;
   int         busy_fall_edge;
   logic       en_prev;
   logic       busy_prev_obs;
   logic [7:0] en_data [$];

   task automatic chk_b(input string tag, input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b (edge %0d)", tag, obs, exp, e);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, e);
      end
   endtask

   task automatic chk_i(input string tag, input int obs, input int exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      e           = 0;
      m_t0        = -1;
      m_total     = 0;
      m_en        = 1'b0;
      m_rs        = 1'b0;
      m_data      = 8'h00;
      m_on        = 1'b0;
      m_pwrup     = INIT_BUILD;
      m_busy      = INIT_BUILD;
      m_init_left = INIT_BUILD ? 6 : 0;
   endtask

   task automatic start_txn(input logic s, input logic [7:0] d);
      m_t0    = e;
      m_rs    = s;
      m_data  = d;
      m_total = S_CYC + P_CYC + H_CYC +
                ((!s && d >= 8'd1 && d <= 8'd3) ? L_CYC : E_CYC);
   endtask

   task automatic model_edge(input logic r, input logic s, input logic [7:0] d);
      logic busy_prev;
      int   k;
      logic txn_busy;
      busy_prev = m_busy;
      e++;
      m_on = 1'b1;
      if (m_pwrup) begin
         if (e == PU_CYC) begin
            m_pwrup = 1'b0;
            start_txn(1'b0, init_rom[0]);
            m_init_left = 5;
         end
      end else if (m_t0 >= 0 && (e - m_t0) == m_total && m_init_left > 0) begin
         start_txn(1'b0, init_rom[6 - m_init_left]);
         m_init_left--;
      end else if (r && !busy_prev) begin
         start_txn(s, d);
      end
      txn_busy = 1'b0;
      m_en     = 1'b0;
      if (m_t0 >= 0) begin
         k        = e - m_t0;
         txn_busy = (k < m_total);
         m_en     = (k >= S_CYC) && (k < S_CYC + P_CYC);
      end
      m_busy = m_pwrup || txn_busy;
   endtask

   task automatic check_outputs();
      chk_b("busy", busy_o, m_busy);
      chk_b("en", lcd_en_o, m_en);
      chk_b("rs", lcd_rs_o, m_rs);
      chk8("data", lcd_data_o, m_data);
      chk_b("on", lcd_on_o, m_on);
      chk_b("rw", lcd_rw_o, 1'b0);
   endtask

   task automatic check_reset(input string tag);
      chk_b({tag, "_busy"}, busy_o, INIT_BUILD);
      chk_b({tag, "_on"}, lcd_on_o, 1'b0);
      chk_b({tag, "_en"}, lcd_en_o, 1'b0);
      chk_b({tag, "_rs"}, lcd_rs_o, 1'b0);
      chk_b({tag, "_rw"}, lcd_rw_o, 1'b0);
      chk8({tag, "_data"}, lcd_data_o, 8'h00);
   endtask

   task automatic obs_reset();
      en_pulses      = 0;
      busy_cnt       = 0;
      first_en_edge  = -1;
      busy_fall_edge = -1;
      en_prev        = lcd_en_o;
      busy_prev_obs  = busy_o;
      en_data.delete();
   endtask

   // One clock: drive at the falling edge, sample at the next falling edge.
   task automatic cyc(input logic r, input logic s, input logic [7:0] d);
      req_i  = r;
      rs_i   = s;
      data_i = d;
      @(posedge clk_i);
      model_edge(r, s, d);
      @(negedge clk_i);
      req_i = 1'b0;
      check_outputs();
      if (busy_o) busy_cnt++;
      if (lcd_en_o && !en_prev) begin
         en_pulses++;
         en_data.push_back(lcd_data_o);
         if (first_en_edge < 0) first_en_edge = e;
      end
      if (!busy_o && busy_prev_obs && busy_fall_edge < 0) busy_fall_edge = e;
      en_prev       = lcd_en_o;
      busy_prev_obs = busy_o;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int         acc;
      logic [7:0] got;
      logic       r;
      logic       s;
      logic [7:0] d;

      rst_i  = 1'b1;
      req_i  = 1'b0;
      rs_i   = 1'b0;
      data_i = 8'h00;
      model_reset();
      #1;
      check_reset("reset");
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
      check_outputs();

`ifdef LCD_INIT_EN
      obs_reset();
      for (int i = 0; i < 200; i++) begin
         if (!m_busy) break;
         cyc(e + 1 == 25, 1'b1, 8'h55);
      end
      chk_b("init_done", busy_o, 1'b0);
      chk_i("init_pulses", en_pulses, 6);
      for (int i = 0; i < 6; i++) begin
         got = (i < en_data.size()) ? en_data[i] : 8'hxx;
         chk8("init_cmd", got, init_rom[i]);
      end
      chk_i("init_busy_fall", busy_fall_edge, INIT_LEN);
`endif

      repeat (3) cyc(1'b0, 1'b0, 8'h00);

      // data write: latency, E window, busy length
      obs_reset();
      cyc(1'b1, 1'b1, 8'h41);
      acc = e;
      repeat (NORMAL_LEN + 4) cyc(1'b0, 1'b0, 8'h00);
      chk_i("wr_en_rise", first_en_edge, acc + S_CYC);
      chk_i("wr_busy_fall", busy_fall_edge, acc + NORMAL_LEN);
      chk_i("wr_busy_cnt", busy_cnt, NORMAL_LEN);
      chk_i("wr_pulses", en_pulses, 1);

      // clear uses the long wait, command 00 does not
      obs_reset();
      cyc(1'b1, 1'b0, 8'h01);
      repeat (LONG_LEN + 4) cyc(1'b0, 1'b0, 8'h00);
      chk_i("clear_busy_cnt", busy_cnt, 37);
      obs_reset();
      cyc(1'b1, 1'b0, 8'h00);
      repeat (NORMAL_LEN + 4) cyc(1'b0, 1'b0, 8'h00);
      chk_i("cmd00_busy_cnt", busy_cnt, 17);

      // request during PULSE is dropped
      obs_reset();
      cyc(1'b1, 1'b1, 8'h41);
      for (int i = 0; i < 20; i++) begin
         if (m_en) break;
         cyc(1'b0, 1'b0, 8'h00);
      end
      cyc(1'b1, 1'b1, 8'h42);
      repeat (NORMAL_LEN + 4) cyc(1'b0, 1'b0, 8'h00);
      chk_i("drop_pulses", en_pulses, 1);
      chk8("drop_data", lcd_data_o, 8'h41);
      chk_i("drop_busy_cnt", busy_cnt, NORMAL_LEN);

      // back-to-back: requests while busy (incl. the final busy cycle) are
      // dropped, the first one seen with busy low is taken
      obs_reset();
      cyc(1'b1, 1'b1, 8'h30);
      for (int i = 0; i < 40; i++) begin
         if (!m_busy) break;
         cyc(1'b1, 1'b1, 8'h7E);
      end
      cyc(1'b1, 1'b1, 8'h31);
      repeat (NORMAL_LEN + 4) cyc(1'b0, 1'b0, 8'h00);
      chk_i("b2b_pulses", en_pulses, 2);
      got = (en_data.size() > 1) ? en_data[1] : 8'hxx;
      chk8("b2b_second", got, 8'h31);
      chk_i("b2b_busy_cnt", busy_cnt, 2 * NORMAL_LEN);

      // asynchronous reset while E is high
      obs_reset();
      cyc(1'b1, 1'b1, 8'h5A);
      for (int i = 0; i < 20; i++) begin
         if (m_en) break;
         cyc(1'b0, 1'b0, 8'h00);
      end
      chk_b("en_before_rst", lcd_en_o, 1'b1);
      #2 rst_i = 1'b1;
      #1;
      check_reset("rst_mid");
      model_reset();
      @(negedge clk_i);
      rst_i = 1'b0;
      check_outputs();
`ifdef LCD_INIT_EN
      for (int i = 0; i < 200; i++) begin
         if (!m_busy) break;
         cyc(1'b0, 1'b0, 8'h00);
      end
      chk_b("reinit_done", busy_o, 1'b0);
`endif
      obs_reset();
      cyc(1'b1, 1'b0, 8'h80);
      repeat (NORMAL_LEN + 4) cyc(1'b0, 1'b0, 8'h00);
      chk_i("post_rst_pulses", en_pulses, 1);
      chk8("post_rst_data", lcd_data_o, 8'h80);

      // random traffic against the model
      for (int i = 0; i < 800; i++) begin
         r = ($urandom_range(0, 3) == 0);
         s = 1'($urandom_range(0, 1));
         d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3))
                                         : 8'($urandom_range(0, 255));
         cyc(r, s, d);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
